// File: rtl/pixel_mixer_if.sv
// Read side of the background/sprite pixel FIFOs as seen by the pixel mixer.
// The mixer is the master (it issues pop_out); the FIFO pair is the slave.
interface pixel_mixer_if;
    logic       pop_out;
    logic [1:0] bg_pixel_in;
    logic       bg_valid_in;
    logic [1:0] sprite_pixel_in;
    logic       sprite_valid_in;
    logic       sprite_palette_in;
    logic       sprite_priority_in;

    modport master (
        output pop_out,
        input  bg_pixel_in, bg_valid_in,
        input  sprite_pixel_in, sprite_valid_in, sprite_palette_in, sprite_priority_in
    );

    modport slave (
        input  pop_out,
        output bg_pixel_in, bg_valid_in,
        output sprite_pixel_in, sprite_valid_in, sprite_palette_in, sprite_priority_in
    );
endinterface

// File: rtl/pixel_mixer.sv
// Mode-3 pixel mixer: pops BG/sprite FIFOs, drops fine-scroll pixels, resolves priority,
// maps through DMG palettes and emits one shade per screen X with end-of-line pulse.
module pixel_mixer #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 144
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tclk_in,
    input  logic                     line_start_in,
    input  logic [7:0]               LY_in,
    input  logic [7:0]               SCX_in,
    input  logic                     bg_ena_in,
    input  logic                     sprite_ena_in,
    input  logic                     stall_in,
    pixel_mixer_if.master            fifo,
    input  logic [7:0]               BGP_in,
    input  logic [7:0]               OBP0_in,
    input  logic [7:0]               OBP1_in,
    output logic [$clog2(X_MAX)-1:0] X_out,
    output logic [1:0]               lcd_pixel_out,
    output logic [$clog2(X_MAX)-1:0] lcd_x_out,
    output logic [7:0]               lcd_y_out,
    output logic                     lcd_valid_out,
    output logic                     line_done_out
);
    localparam int XW = $clog2(X_MAX);
    localparam int PW = $clog2(X_MAX + 8);

    typedef enum logic [1:0] {IDLE, DISCARD, DRAW, DONE} state_t;

    state_t          r_state;
    logic [7:0]      r_ly;
    logic [2:0]      r_discard;
    logic [PW-1:0]   r_pops_left;
    logic [XW-1:0]   r_x;
    logic [1:0]      r_pix_p1;
    logic [XW-1:0]   r_x_p1;
    logic            r_vld_p1;
    logic            r_done_p1;

    logic            w_start;
    logic            w_pop;
    logic [1:0]      w_shade;

    function automatic logic [1:0] pal_lookup(input logic [7:0] pal, input logic [1:0] idx);
        case (idx)
            2'd0:    return pal[1:0];
            2'd1:    return pal[3:2];
            2'd2:    return pal[5:4];
            default: return pal[7:6];
        endcase
    endfunction

    // A sprite with the behind-BG flag only shows through BG colour index 0.
    function automatic logic [1:0] mix_shade(
        input logic [1:0] bg_pix, input logic bg_ena,
        input logic [1:0] sp_pix, input logic sp_vld, input logic sp_ena,
        input logic sp_pal, input logic sp_prio,
        input logic [7:0] bgp, input logic [7:0] obp0, input logic [7:0] obp1
    );
        logic [1:0] bidx;
        logic [1:0] sidx;
        bidx = bg_ena ? bg_pix : 2'd0;
        sidx = (sp_vld && sp_ena) ? sp_pix : 2'd0;
        if (sidx != 2'd0 && (!sp_prio || bidx == 2'd0))
            return pal_lookup(sp_pal ? obp1 : obp0, sidx);
        else if (!bg_ena)
            return 2'b00;
        else
            return pal_lookup(bgp, bidx);
    endfunction

    assign w_start = line_start_in && (LY_in < 8'(Y_MAX));
    assign w_pop   = tclk_in && (r_state == DISCARD || r_state == DRAW) && !stall_in
                     && (r_pops_left != '0);
    assign w_shade = mix_shade(fifo.bg_pixel_in, bg_ena_in,
                               fifo.sprite_pixel_in, fifo.sprite_valid_in, sprite_ena_in,
                               fifo.sprite_palette_in, fifo.sprite_priority_in,
                               BGP_in, OBP0_in, OBP1_in);

    assign fifo.pop_out  = w_pop;
    assign X_out         = r_x;
    assign lcd_pixel_out = r_pix_p1;
    assign lcd_x_out     = r_x_p1;
    assign lcd_y_out     = r_ly;
    assign lcd_valid_out = r_vld_p1;
    assign line_done_out = r_done_p1;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_ly        <= '0;
            r_discard   <= '0;
            r_pops_left <= '0;
            r_x         <= '0;
            r_pix_p1    <= '0;
            r_x_p1      <= '0;
            r_vld_p1    <= 1'b0;
            r_done_p1   <= 1'b0;
        end else begin
            r_vld_p1  <= 1'b0;
            r_done_p1 <= 1'b0;
            if (w_pop)
                r_pops_left <= r_pops_left - 1'b1;
            // A new line start overrides whatever the current line was doing.
            if (w_start) begin
                r_ly        <= LY_in;
                r_discard   <= SCX_in[2:0];
                r_pops_left <= PW'(X_MAX) + PW'(SCX_in[2:0]);
                r_x         <= '0;
                r_state     <= (SCX_in[2:0] != 3'd0) ? DISCARD : DRAW;
            end else begin
                case (r_state)
                    DISCARD: if (fifo.bg_valid_in) begin
                        r_discard <= r_discard - 3'd1;
                        if (r_discard == 3'd1)
                            r_state <= DRAW;
                    end
                    DRAW: if (fifo.bg_valid_in) begin
                        // ---- stage p1: registered LCD output ----
                        r_pix_p1 <= w_shade;
                        r_x_p1   <= r_x;
                        r_vld_p1 <= 1'b1;
                        if (r_x == XW'(X_MAX - 1)) begin
                            r_done_p1 <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pixel_mixer.sv
// Randomised scoreboard bench for pixel_mixer: a FIFO model answers pops, a line-level
// reference predicts every LCD pixel and a negedge monitor compares the DUT output stream.
module tb_pixel_mixer;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 144;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       tclk_in = 1'b0, line_start_in = 1'b0, stall_in = 1'b0;
    logic       bg_ena_in = 1'b0, sprite_ena_in = 1'b0;
    logic [7:0] LY_in = '0, SCX_in = '0, BGP_in = '0, OBP0_in = '0, OBP1_in = '0;
    logic [7:0] X_out, lcd_x_out, lcd_y_out;
    logic [1:0] lcd_pixel_out;
    logic       lcd_valid_out, line_done_out;

    always #5 clk_in = ~clk_in;

    pixel_mixer_if fifo();

    pixel_mixer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .line_start_in(line_start_in),
        .LY_in(LY_in), .SCX_in(SCX_in), .bg_ena_in(bg_ena_in), .sprite_ena_in(sprite_ena_in),
        .stall_in(stall_in), .fifo(fifo), .BGP_in(BGP_in), .OBP0_in(OBP0_in), .OBP1_in(OBP1_in),
        .X_out(X_out), .lcd_pixel_out(lcd_pixel_out), .lcd_x_out(lcd_x_out),
        .lcd_y_out(lcd_y_out), .lcd_valid_out(lcd_valid_out), .line_done_out(line_done_out)
    );

    typedef struct {int pix; int x; int y; int done;} exp_t;
    exp_t q[$];
    exp_t mon_e;

    int n_pass = 0, n_total = 0;

    // Reference line state
    bit m_active = 0;
    int m_idx = 0, m_scx = 0, m_ly = 0, m_out = 0;

    // Stimulus knobs
    int bg_fix = -1;
    int sp_mode = 0;
    int sp_fix = 0, prio_fix = 0, pal_fix = 0;
    bit rnd_cfg = 0, tclk_rand = 0, ls_req = 0, pend = 0;
    int stall_left = 0, pop_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int ref_shade(input int b_raw, input bit bgen, input int s_raw,
                                     input bit sv, input bit sen, input bit spal, input bit sprio,
                                     input int bgp, input int obp0, input int obp1);
        int b, s, pal;
        b = bgen ? b_raw : 0;
        s = (sv && sen) ? s_raw : 0;
        if (s != 0 && (!sprio || b == 0)) begin
            pal = spal ? obp1 : obp0;
            return (pal >> (2 * s)) & 3;
        end
        if (!bgen) return 0;
        return (bgp >> (2 * b)) & 3;
    endfunction

    // One clock of stimulus: FIFO answers last cycle's pop, reference consumes the same inputs.
    task automatic step();
        bit   ls_now;
        int   x;
        exp_t e;
        @(posedge clk_in);
        #1;
        ls_now = ls_req;
        ls_req = 0;
        line_start_in = ls_now;
        fifo.bg_valid_in = pend;
        fifo.bg_pixel_in = (bg_fix >= 0) ? 2'(bg_fix) : 2'($urandom_range(0, 3));
        case (sp_mode)
            0: begin
                fifo.sprite_valid_in    = 1'b0;
                fifo.sprite_pixel_in    = 2'($urandom_range(0, 3));
                fifo.sprite_palette_in  = 1'($urandom_range(0, 1));
                fifo.sprite_priority_in = 1'($urandom_range(0, 1));
            end
            1: begin
                fifo.sprite_valid_in    = 1'($urandom_range(0, 1));
                fifo.sprite_pixel_in    = 2'($urandom_range(0, 3));
                fifo.sprite_palette_in  = 1'($urandom_range(0, 1));
                fifo.sprite_priority_in = 1'($urandom_range(0, 1));
            end
            default: begin
                fifo.sprite_valid_in    = 1'b1;
                fifo.sprite_pixel_in    = 2'(sp_fix);
                fifo.sprite_palette_in  = 1'(pal_fix);
                fifo.sprite_priority_in = 1'(prio_fix);
            end
        endcase
        if (rnd_cfg) begin
            bg_ena_in     = ($urandom_range(0, 3) != 0);
            sprite_ena_in = ($urandom_range(0, 3) != 0);
            BGP_in        = 8'($urandom);
            OBP0_in       = 8'($urandom);
            OBP1_in       = 8'($urandom);
        end
        tclk_in = ls_now ? 1'b0 : (tclk_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (stall_left > 0) begin
            stall_in = 1'b1;
            if (tclk_in) stall_left--;
        end else begin
            stall_in = 1'b0;
        end

        if (ls_now && LY_in < Y_MAX) begin
            m_active = 1;
            m_ly     = LY_in;
            m_scx    = SCX_in & 7;
            m_idx    = 0;
            m_out    = 0;
            pop_cnt  = 0;
        end else if (fifo.bg_valid_in && m_active) begin
            if (m_idx >= m_scx) begin
                x = m_idx - m_scx;
                e.pix  = ref_shade(fifo.bg_pixel_in, bg_ena_in, fifo.sprite_pixel_in,
                                   fifo.sprite_valid_in, sprite_ena_in, fifo.sprite_palette_in,
                                   fifo.sprite_priority_in, BGP_in, OBP0_in, OBP1_in);
                e.x    = x;
                e.y    = m_ly;
                e.done = (x == X_MAX - 1);
                q.push_back(e);
                m_out++;
                if (x == X_MAX - 1) m_active = 0;
            end
            m_idx++;
        end

        @(negedge clk_in);
        pend = fifo.pop_out;
        if (fifo.pop_out) pop_cnt++;
        if (stall_in) chk("no_pop_during_stall", fifo.pop_out, 0);
    endtask

    always @(negedge clk_in) begin
        if (lcd_valid_out) begin
            if (q.size() == 0) begin
                chk("unexpected_pixel", 1, 0);
            end else begin
                mon_e = q.pop_front();
                n_total++;
                if (lcd_pixel_out == mon_e.pix && lcd_x_out == mon_e.x &&
                    lcd_y_out == mon_e.y && line_done_out == mon_e.done)
                    n_pass++;
                else
                    $display("FAIL pixel: got shade=%0d x=%0d y=%0d done=%0d expected shade=%0d x=%0d y=%0d done=%0d",
                             lcd_pixel_out, lcd_x_out, lcd_y_out, line_done_out,
                             mon_e.pix, mon_e.x, mon_e.y, mon_e.done);
            end
        end else if (line_done_out) begin
            chk("done_without_valid", 1, 0);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_pop"}, fifo.pop_out, 0);
        chk({tag, "_lcd_valid"}, lcd_valid_out, 0);
        chk({tag, "_lcd_pixel"}, lcd_pixel_out, 0);
        chk({tag, "_lcd_x"}, lcd_x_out, 0);
        chk({tag, "_lcd_y"}, lcd_y_out, 0);
        chk({tag, "_line_done"}, line_done_out, 0);
        chk({tag, "_X"}, X_out, 0);
    endtask

    task automatic run_line(input int ly, input int scx, input int abort_at, input int stall_at);
        int cyc;
        bit aborted, stalled;
        LY_in  = 8'(ly);
        SCX_in = 8'(scx);
        ls_req = 1;
        step();
        aborted = 0;
        stalled = 0;
        cyc = 0;
        while ((m_active || q.size() != 0) && cyc < 3000) begin
            if (abort_at >= 0 && !aborted && m_out == abort_at) begin
                ls_req  = 1;
                aborted = 1;
            end
            if (stall_at >= 0 && !stalled && m_out == stall_at) begin
                stall_left = 6;
                stalled    = 1;
            end
            step();
            cyc++;
        end
        chk("line_timeout", int'(cyc < 3000), 1);
        repeat (4) step();
        chk("pop_count", pop_cnt, X_MAX + (scx & 7));
        chk("X_hold_at_end", X_out, X_MAX - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        fifo.bg_valid_in = 1'b0;
        fifo.bg_pixel_in = '0;
        fifo.sprite_valid_in = 1'b0;
        fifo.sprite_pixel_in = '0;
        fifo.sprite_palette_in = 1'b0;
        fifo.sprite_priority_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_zero("reset");
        rst_in = 1'b1;

        // Flat BG index 1 through BGP=E4 gives shade 1 everywhere
        bg_ena_in = 1; sprite_ena_in = 1; BGP_in = 8'hE4; OBP0_in = 8'h27; OBP1_in = 8'h1B;
        bg_fix = 1; sp_mode = 0; tclk_rand = 0;
        run_line(5, 0, -1, -1);

        // Fine scroll of 3 with random BG/sprite data
        bg_fix = -1; sp_mode = 1;
        run_line(7, 3, -1, -1);

        // Behind-BG sprite loses to BG index 2, wins over BG index 0 via OBP1
        bg_fix = 2; sp_mode = 2; sp_fix = 3; prio_fix = 1; pal_fix = 1;
        run_line(10, 0, -1, -1);
        bg_fix = 0;
        run_line(11, 0, -1, -1);

        // Stall mid-line with irregular T-cycle strobes
        bg_fix = -1; sp_mode = 1; tclk_rand = 1;
        run_line(30, 5, -1, 50);

        // Restart at X=80
        run_line(40, 2, 80, -1);

        // Line start for LY beyond the visible area is ignored
        LY_in = 8'd150; SCX_in = 8'd0; pop_cnt = 0; ls_req = 1;
        step();
        repeat (10) step();
        chk("ignored_line_pops", pop_cnt, 0);

        // Fully random configuration
        rnd_cfg = 1;
        for (int i = 0; i < 3; i++)
            run_line($urandom_range(0, Y_MAX - 1), $urandom_range(0, 255), -1,
                     $urandom_range(10, 150));

        // Asynchronous reset in the middle of drawing
        rnd_cfg = 0; tclk_rand = 0;
        LY_in = 8'd20; SCX_in = 8'd0; ls_req = 1;
        step();
        cyc = 0;
        while (m_out < 40 && cyc < 1000) begin
            step();
            cyc++;
        end
        chk("reset_line_timeout", int'(cyc < 1000), 1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        q.delete();
        m_active = 0;
        pend = 0;
        fifo.bg_valid_in = 1'b0;
        #1;
        check_zero("midline_reset");
        pop_cnt = 0;
        repeat (3) step();
        rst_in = 1'b1;
        repeat (8) step();
        chk("pops_after_reset", pop_cnt, 0);

        // Recovery after reset
        tclk_rand = 1;
        run_line(60, 6, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
